// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one synchronous FIFO write port among NUM_REQ requesters
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, sel;
  logic [CW-1:0] burst_cnt;
  logic found, xfer, rel;
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        sel   = IW'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  // a write never happens in a reset cycle, even mid-burst
  assign xfer       = !rst && state == GRANT && req[grant_id] && !fifo_full;
  assign rel        = state == GRANT && (!req[grant_id] ||
                      (xfer && (req_last[grant_id] || burst_cnt == CW'(MAX_BURST - 1))));
  assign state_nxt  = state == IDLE ? (found ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  assign busy       = state == GRANT;
  assign fifo_wr_en = xfer;
  assign req_ack    = xfer ? NUM_REQ'(1) << grant_id : '0;
  assign fifo_data  = busy ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        grant_id  <= sel;
        burst_cnt <= '0;
      end
      if (state == GRANT) begin
        burst_cnt <= rel ? '0 : burst_cnt + CW'(xfer);
        if (rel) rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random stimulus checked each cycle against a behavioural arbiter model
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, MB = 4;
  logic clk = 0, rst;
  logic [N-1:0] req, req_last, req_ack;
  logic [N*W-1:0] req_data;
  logic fifo_full, fifo_wr_en, busy;
  logic [W-1:0] fifo_data;
  logic [1:0] grant_id;
  int errors = 0, checks = 0;
  int owner = -1, words = 0, ptr = 0, last_gid = 0, wr_cnt = 0;
  logic [W-1:0] wq[$];
  int gq[$];
  logic prev_busy = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    logic xfer;
    logic [N-1:0] eack;
    logic [W-1:0] edata;
    #1;
    xfer  = !rst && owner >= 0 && req[owner] && !fifo_full;
    eack  = xfer ? (4'b0001 << owner) : 4'b0000;
    edata = (owner >= 0) ? req_data[owner*W +: W] : '0;
    check("wr_en", {31'b0, fifo_wr_en}, {31'b0, xfer});
    check("ack", {28'b0, req_ack}, {28'b0, eack});
    check("data", {24'b0, fifo_data}, {24'b0, edata});
    check("busy", {31'b0, busy}, owner >= 0);
    check("gid", {30'b0, grant_id}, last_gid);
    if (fifo_wr_en) begin wr_cnt++; wq.push_back(fifo_data); end
    if (busy && !prev_busy) gq.push_back(int'(grant_id));
    prev_busy = busy;
    @(posedge clk);
    if (rst) begin
      owner = -1; ptr = 0; last_gid = 0; words = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++)
        if (owner < 0 && req[(ptr + k) % N]) owner = (ptr + k) % N;
      if (owner >= 0) begin last_gid = owner; words = 0; end
    end else if (!req[owner]) begin
      ptr = (owner + 1) % N; owner = -1;
    end else if (xfer) begin
      words++;
      if (req_last[owner] || words == MB) begin ptr = (owner + 1) % N; owner = -1; end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1; req = '1; req_last = '0; fifo_full = 0; req_data = '0;
    @(posedge clk); #1;
    // T1 reset with all requests high
    do_reset(2);
    check("t1_gid", {30'b0, grant_id}, 0);
    check("t1_busy", {31'b0, busy}, 0);
    cycle();
    check("t1_first_gid", {30'b0, grant_id}, 0);
    check("t1_first_busy", {31'b0, busy}, 1);
    // T2 single three-word burst from requester 1
    req = '0; do_reset(1);
    req = 4'b0010; req_data[1*W +: W] = 8'hA1; wq.delete();
    cycle();
    check("t2_busy", {31'b0, busy}, 1);
    check("t2_gid", {30'b0, grant_id}, 1);
    cycle();
    req_data[1*W +: W] = 8'hA2; cycle();
    req_data[1*W +: W] = 8'hA3; req_last = 4'b0010; cycle();
    check("t2_release", {31'b0, busy}, 0);
    req = '0; req_last = '0;
    check("t2_count", wq.size(), 3);
    if (wq.size() == 3) begin
      check("t2_w0", {24'b0, wq[0]}, 32'hA1);
      check("t2_w1", {24'b0, wq[1]}, 32'hA2);
      check("t2_w2", {24'b0, wq[2]}, 32'hA3);
    end
    // T3 round-robin with every requester active
    do_reset(1);
    req = '1; wr_cnt = 0; gq.delete();
    repeat (20) cycle();
    check("t3_writes", wr_cnt, 16);
    repeat (2) cycle();
    check("t3_grants", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("t3_order", gq[i], i % 4);
    // T4 fifo full stall mid-burst
    req = '0; do_reset(1);
    req = 4'b0001; wr_cnt = 0;
    repeat (3) cycle();
    fifo_full = 1;
    repeat (3) cycle();
    check("t4_stalled", wr_cnt, 2);
    fifo_full = 0;
    repeat (2) cycle();
    check("t4_total", wr_cnt, 4);
    check("t4_release", {31'b0, busy}, 0);
    // T5 withdraw, next grant to 3 then to 0
    req = '0; do_reset(1);
    req = 4'b0100; req_data = {$urandom, $urandom};
    repeat (2) cycle();
    req = 4'b1000; wr_cnt = 0;
    cycle();
    check("t5_nowrite", wr_cnt, 0);
    check("t5_release", {31'b0, busy}, 0);
    cycle();
    check("t5_gid3", {30'b0, grant_id}, 3);
    req = '0; do_reset(1);
    req = 4'b0100;
    repeat (2) cycle();
    req = 4'b0001;
    repeat (2) cycle();
    check("t5_gid0", {30'b0, grant_id}, 0);
    check("t5_busy0", {31'b0, busy}, 1);
    // T6 reset during requester 3 burst
    req = '0; do_reset(1);
    req = 4'b1000;
    repeat (2) cycle();
    wr_cnt = 0; rst = 1;
    cycle();
    rst = 0;
    check("t6_nowrite", wr_cnt, 0);
    check("t6_idle", {31'b0, busy}, 0);
    req = '1;
    cycle();
    check("t6_gid", {30'b0, grant_id}, 0);
    // random traffic
    repeat (3000) begin
      rst       = ($urandom % 64) == 0;
      req       = ($urandom % 3 == 0) ? 4'($urandom) : req;
      req_last  = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
      fifo_full = ($urandom % 4) == 0;
      req_data  = {$urandom};
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
